sdram_access_sched: RTL and testbench

//  Schedules all SDRAM traffic for the OV7670 -> SDRAM -> VGA frame buffer.
//  - Arbitrates between periodic auto-refresh, camera write bursts (write FIFO has data) and VGA read bursts (read FIFO has room).
//  - Generates linear, frame-wrapping burst addresses and drives the 2-bit command/address handshake of the SDRAM command engine.

---
 rtl/sdram_access_sched_if.sv | 19 +
 rtl/sdram_access_sched.sv | 208 ++++++++++++++++++++
 tb/tb_sdram_access_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_access_sched_if.sv
// Command/address handshake between the access scheduler and the SDRAM
// command engine. The scheduler holds a command until the engine acks it.
interface sdram_access_sched_if;
    logic [1:0]  ctrl_cmd;   // 00 idle, 01 write, 10 read, 11 refresh
    logic [21:0] sys_addr;   // burst start word address
    logic        cmd_ack;    // one-cycle pulse: current command finished

    modport master (
        output ctrl_cmd,
        output sys_addr,
        input  cmd_ack
    );

    modport slave (
        input  ctrl_cmd,
        input  sys_addr,
        output cmd_ack
    );
endinterface

// File: rtl/sdram_access_sched.sv
// SDRAM access scheduler for the camera -> SDRAM -> VGA frame buffer.
// Arbitrates periodic refresh, camera write bursts and VGA read bursts, and
// generates linear frame-wrapping burst addresses.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | no command outstanding; arbitrate and grant on this cycle
//   S_WRITE   | write burst issued, waiting for cmd_ack
//   S_READ    | read burst issued, waiting for cmd_ack
//   S_REFRESH | auto-refresh issued, waiting for cmd_ack
module sdram_access_sched #(
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int REF_PERIOD  = 780,
    parameter int FIFO_AW     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sdram_init_done_i,
    input  logic [FIFO_AW:0]     wr_fifo_level_i,
    input  logic [FIFO_AW:0]     rd_fifo_level_i,
    input  logic                 wr_frame_start_i,
    input  logic                 rd_frame_start_i,
    sdram_access_sched_if.master bus,
    output logic                 wr_burst_done_o,
    output logic                 rd_burst_done_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_REFRESH = 2'd3
    } state_t;

    localparam int                RCW       = $clog2(REF_PERIOD);
    localparam logic [RCW-1:0]    REF_LAST  = RCW'(REF_PERIOD - 1);
    localparam logic [FIFO_AW:0]  WR_THR    = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [FIFO_AW:0]  RD_THR    = (FIFO_AW + 1)'((2 ** FIFO_AW) - BURST_LEN);
    localparam logic [21:0]       BURST_INC = 22'(BURST_LEN);
    // A full 2**22 frame truncates to 0, which matches the natural wrap.
    localparam logic [21:0]       FRAME_END = 22'(FRAME_WORDS);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    state_t         state_q;
    logic [1:0]     ctrl_cmd_q;
    logic [21:0]    sys_addr_q;
    logic           wr_done_q, rd_done_q;
    logic           last_rd_q;          // 1: last read/write grant was a read
    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
    logic           ref_pend_q, ref_pend_d;
    logic [21:0]    wr_addr_q, wr_addr_d;
    logic [21:0]    rd_addr_q, rd_addr_d;
    logic           wr_rst_q, wr_rst_d;
    logic           rd_rst_q, rd_rst_d;

    logic           wr_req, rd_req, can_grant;
    logic           grant_ref, grant_wr, grant_rd;
    logic           wr_ack, rd_ack, ref_ack, ref_wrap;
    logic [21:0]    wr_addr_inc, rd_addr_inc;

    // Request decode, arbitration and next-state values for counters/addresses
    always_comb begin
        wr_req    = (wr_fifo_level_i >= WR_THR);
        rd_req    = (rd_fifo_level_i <= RD_THR);
        can_grant = (state_q == S_IDLE) && sdram_init_done_i;

        // Refresh first; on a tie the side that was not granted last wins.
        grant_ref = can_grant && ref_pend_q;
        grant_wr  = can_grant && !ref_pend_q && wr_req && (!rd_req || last_rd_q);
        grant_rd  = can_grant && !ref_pend_q && rd_req && (!wr_req || !last_rd_q);

        wr_ack    = (state_q == S_WRITE)   && bus.cmd_ack;
        rd_ack    = (state_q == S_READ)    && bus.cmd_ack;
        ref_ack   = (state_q == S_REFRESH) && bus.cmd_ack;
        ref_wrap  = sdram_init_done_i && (ref_cnt_q == REF_LAST);

        ref_cnt_d = ref_cnt_q;
        if (!sdram_init_done_i) begin
            ref_cnt_d = '0;
        end else if (ref_wrap) begin
            ref_cnt_d = '0;
        end else begin
            ref_cnt_d = ref_cnt_q + RCW'(1);
        end

        // Only one refresh is ever outstanding; a fresh wrap beats a same-cycle ack.
        ref_pend_d = ref_pend_q;
        if (ref_wrap) begin
            ref_pend_d = 1'b1;
        end else if (ref_ack) begin
            ref_pend_d = 1'b0;
        end

        wr_addr_inc = wr_addr_q + BURST_INC;
        if (wr_addr_inc == FRAME_END) begin
            wr_addr_inc = '0;
        end
        rd_addr_inc = rd_addr_q + BURST_INC;
        if (rd_addr_inc == FRAME_END) begin
            rd_addr_inc = '0;
        end

        // A frame start while its address is in use is deferred to the ack.
        wr_addr_d = wr_addr_q;
        wr_rst_d  = wr_rst_q;
        if (wr_ack) begin
            wr_addr_d = (wr_rst_q || wr_frame_start_i) ? '0 : wr_addr_inc;
            wr_rst_d  = 1'b0;
        end else if (wr_frame_start_i) begin
            if ((state_q == S_WRITE) || grant_wr) begin
                wr_rst_d = 1'b1;
            end else begin
                wr_addr_d = '0;
            end
        end

        rd_addr_d = rd_addr_q;
        rd_rst_d  = rd_rst_q;
        if (rd_ack) begin
            rd_addr_d = (rd_rst_q || rd_frame_start_i) ? '0 : rd_addr_inc;
            rd_rst_d  = 1'b0;
        end else if (rd_frame_start_i) begin
            if ((state_q == S_READ) || grant_rd) begin
                rd_rst_d = 1'b1;
            end else begin
                rd_addr_d = '0;
            end
        end
    end

    // Refresh timer, burst addresses and deferred frame-restart flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_rst_q   <= 1'b0;
            rd_rst_q   <= 1'b0;
        end else begin
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_rst_q   <= wr_rst_d;
            rd_rst_q   <= rd_rst_d;
        end
    end

    // Command FSM with registered command, address and burst-done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctrl_cmd_q <= CMD_IDLE;
            sys_addr_q <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            last_rd_q  <= 1'b1;
        end else begin
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_ref) begin
                        state_q    <= S_REFRESH;
                        ctrl_cmd_q <= CMD_REF;
                        sys_addr_q <= '0;
                    end else if (grant_wr) begin
                        state_q    <= S_WRITE;
                        ctrl_cmd_q <= CMD_WRITE;
                        sys_addr_q <= wr_addr_q;
                        last_rd_q  <= 1'b0;
                    end else if (grant_rd) begin
                        state_q    <= S_READ;
                        ctrl_cmd_q <= CMD_READ;
                        sys_addr_q <= rd_addr_q;
                        last_rd_q  <= 1'b1;
                    end
                end
                S_WRITE, S_READ, S_REFRESH: begin
                    if (bus.cmd_ack) begin
                        state_q    <= S_IDLE;
                        ctrl_cmd_q <= CMD_IDLE;
                        sys_addr_q <= '0;
                        wr_done_q  <= (state_q == S_WRITE);
                        rd_done_q  <= (state_q == S_READ);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    ctrl_cmd_q <= CMD_IDLE;
                    sys_addr_q <= '0;
                end
            endcase
        end
    end

    assign bus.ctrl_cmd    = ctrl_cmd_q;
    assign bus.sys_addr    = sys_addr_q;
    assign wr_burst_done_o = wr_done_q;
    assign rd_burst_done_o = rd_done_q;

endmodule

// File: tb/tb_sdram_access_sched.sv
// Directed bench for sdram_access_sched: the bench plays the command engine,
// acking each command after a programmable hold time.
module tb_sdram_access_sched;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic [10:0] wr_level;
    logic [10:0] rd_level;
    logic        wr_fs;
    logic        rd_fs;
    logic        wr_done;
    logic        rd_done;

    int n_checks = 0;
    int n_errors = 0;

    sdram_access_sched_if bus ();

    sdram_access_sched dut (
        .clk               (clk),
        .rst               (rst),
        .sdram_init_done_i (init_done),
        .wr_fifo_level_i   (wr_level),
        .rd_fifo_level_i   (rd_level),
        .wr_frame_start_i  (wr_fs),
        .rd_frame_start_i  (rd_fs),
        .bus               (bus),
        .wr_burst_done_o   (wr_done),
        .rd_burst_done_o   (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a command; optionally ack interleaved refreshes along the way.
    task automatic wait_cmd(input string tag, input logic [1:0] ec, input logic [21:0] ea,
                            input bit skip_ref);
        int n;
        bit got;
        got = 1'b0;
        while (!got) begin
            n = 0;
            while (bus.ctrl_cmd == 2'b00 && n < 3000) begin
                tick();
                n++;
            end
            check_val({tag, "_seen"}, 32'(bus.ctrl_cmd != 2'b00), 1);
            if (bus.ctrl_cmd == 2'b00) return;
            if (skip_ref && bus.ctrl_cmd == 2'b11 && ec != 2'b11) begin
                bus.cmd_ack = 1'b1;
                tick();
                bus.cmd_ack = 1'b0;
            end else begin
                got = 1'b1;
            end
        end
        check_val({tag, "_cmd"},  32'(bus.ctrl_cmd), 32'(ec));
        check_val({tag, "_addr"}, 32'(bus.sys_addr), 32'(ea));
    endtask

    // Hold, ack, and check the return to idle plus the done pulses.
    task automatic finish_cmd(input string tag, input logic [1:0] ec, input logic [21:0] ea,
                              input int hold, input bit fs_wr, input bit fs_rd);
        repeat (hold) tick();
        check_val({tag, "_hold_cmd"},  32'(bus.ctrl_cmd), 32'(ec));
        check_val({tag, "_hold_addr"}, 32'(bus.sys_addr), 32'(ea));
        bus.cmd_ack = 1'b1;
        wr_fs = fs_wr;
        rd_fs = fs_rd;
        tick();
        bus.cmd_ack = 1'b0;
        wr_fs = 1'b0;
        rd_fs = 1'b0;
        check_val({tag, "_ack_cmd"}, 32'(bus.ctrl_cmd), 0);
        check_val({tag, "_wdone"},   32'(wr_done), 32'(ec == 2'b01));
        check_val({tag, "_rdone"},   32'(rd_done), 32'(ec == 2'b10));
        tick();
        check_val({tag, "_wdone_off"}, 32'(wr_done), 0);
        check_val({tag, "_rdone_off"}, 32'(rd_done), 0);
    endtask

    task automatic burst(input string tag, input logic [1:0] ec, input logic [21:0] ea,
                         input int hold);
        wait_cmd(tag, ec, ea, 1'b1);
        finish_cmd(tag, ec, ea, hold, 1'b0, 1'b0);
    endtask

    initial begin
        int bad;
        int n;
        rst         = 1'b1;
        init_done   = 1'b0;
        wr_level    = 11'd1024;
        rd_level    = 11'd0;
        wr_fs       = 1'b0;
        rd_fs       = 1'b0;
        bus.cmd_ack = 1'b0;

        repeat (3) tick();
        check_val("rst_cmd",   32'(bus.ctrl_cmd), 0);
        check_val("rst_addr",  32'(bus.sys_addr), 0);
        check_val("rst_wdone", 32'(wr_done), 0);
        check_val("rst_rdone", 32'(rd_done), 0);
        rst = 1'b0;

        // No grants and no refresh before init completes.
        bad = 0;
        repeat (2000) begin
            tick();
            if (bus.ctrl_cmd != 2'b00) bad++;
        end
        check_val("t1_no_cmd", bad, 0);

        // First refresh exactly 780 cycles after init rises, then every 780.
        wr_level  = 11'd0;
        rd_level  = 11'd1023;
        init_done = 1'b1;
        bad = 0;
        repeat (780) begin
            tick();
            if (bus.ctrl_cmd != 2'b00) bad++;
        end
        check_val("t2_quiet", bad, 0);
        tick();
        check_val("t2_ref_cmd",  32'(bus.ctrl_cmd), 3);
        check_val("t2_ref_addr", 32'(bus.sys_addr), 0);
        finish_cmd("t2_ref0", 2'b11, 22'd0, 2, 1'b0, 1'b0);
        n = 4;
        while (bus.ctrl_cmd == 2'b00 && n < 2000) begin
            tick();
            n++;
        end
        check_val("t2_period", n, 780);
        check_val("t2_ref1_cmd", 32'(bus.ctrl_cmd), 3);
        finish_cmd("t2_ref1", 2'b11, 22'd0, 1, 1'b0, 1'b0);

        // Both requests held: round robin, write first.
        wr_level = 11'd256;
        rd_level = 11'd0;
        for (int i = 0; i < 4; i++) begin
            burst("t3_w", 2'b01, 22'(256 * i), 10);
            burst("t3_r", 2'b10, 22'(256 * i), 10);
        end
        rd_level = 11'd1023;

        // Writes only, through the frame wrap.
        for (int i = 4; i < 1199; i++) begin
            burst("t4_w", 2'b01, 22'(256 * i), 2);
        end
        burst("t4_last", 2'b01, 22'd306944, 2);
        burst("t4_wrap", 2'b01, 22'd0, 2);

        // Frame start during the write at 512 restarts the next write at 0.
        burst("t5_w256", 2'b01, 22'd256, 2);
        wait_cmd("t5_w512", 2'b01, 22'd512, 1'b1);
        wr_fs = 1'b1;
        tick();
        wr_fs = 1'b0;
        finish_cmd("t5_w512", 2'b01, 22'd512, 3, 1'b0, 1'b0);
        wait_cmd("t5_wrst", 2'b01, 22'd0, 1'b1);
        wr_level = 11'd0;
        finish_cmd("t5_wrst", 2'b01, 22'd0, 2, 1'b0, 1'b0);
        // Frame start in idle clears the write address at once.
        repeat (3) tick();
        wr_fs = 1'b1;
        tick();
        wr_fs = 1'b0;
        wr_level = 11'd256;
        wait_cmd("t5_widle", 2'b01, 22'd0, 1'b1);
        wr_level = 11'd0;
        finish_cmd("t5_widle", 2'b01, 22'd0, 2, 1'b0, 1'b0);
        // Read address untouched by write restarts; restart coincident with ack.
        rd_level = 11'd0;
        wait_cmd("t5_r1024", 2'b10, 22'd1024, 1'b1);
        finish_cmd("t5_r1024", 2'b10, 22'd1024, 2, 1'b0, 1'b1);
        wait_cmd("t5_rrst", 2'b10, 22'd0, 1'b1);
        rd_level = 11'd1023;
        finish_cmd("t5_rrst", 2'b10, 22'd0, 2, 1'b0, 1'b0);

        // Realign the refresh timer, then let two wraps land inside one read.
        rst = 1'b1;
        tick();
        rd_level = 11'd0;
        wr_level = 11'd0;
        rst = 1'b0;
        wait_cmd("t6_rd", 2'b10, 22'd0, 1'b0);
        wr_level = 11'd256;
        rd_level = 11'd1023;
        finish_cmd("t6_rd", 2'b10, 22'd0, 1600, 1'b0, 1'b0);
        check_val("t6_ref_first", 32'(bus.ctrl_cmd), 3);
        finish_cmd("t6_ref", 2'b11, 22'd0, 1, 1'b0, 1'b0);
        wait_cmd("t6_w0", 2'b01, 22'd0, 1'b0);
        finish_cmd("t6_w0", 2'b01, 22'd0, 2, 1'b0, 1'b0);
        // Reset in the middle of a write.
        wait_cmd("t6_w256", 2'b01, 22'd256, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_val("t6_rst_cmd",  32'(bus.ctrl_cmd), 0);
        check_val("t6_rst_addr", 32'(bus.sys_addr), 0);
        #1;
        rst = 1'b0;
        wait_cmd("t6_wpost", 2'b01, 22'd0, 1'b1);
        finish_cmd("t6_wpost", 2'b01, 22'd0, 2, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
